// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - next-PC generator with redirect arbitration, stall parking and optional RAS (NEXTPC_RAS_EN)
//
// Producer end of the PC update interface. Redirect requests are arbitrated
// Exception > Return > Call > BranchTaken. A redirect accepted while fetch is
// stalled is parked in PendTarget and issued on the first unstalled cycle.
// Define NEXTPC_RAS_EN to build the return-address stack that supplies Return
// targets. Without it, Return uses JumpTarget and Call only redirects.

module next_pc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          RAS_DEPTH  = 8,
    parameter int          RAS_AW     = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] PC,
    input  logic        Stall,
    input  logic        Exception,
    input  logic        Return,
    input  logic        Call,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] LinkAddr,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PCNext,
    output logic        PCWrite,
    output logic        Pending,
    output logic        RasEmpty,
    output logic        RasFull
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_target;
    logic [31:0] pend_target_nxt;

    // Priority-decoded request lines: exactly one winner at most.
    logic        win_exc;
    logic        win_ret;
    logic        win_call;
    logic        win_br;
    logic        any_req;

    // Target of the winning request, word aligned.
    logic [31:0] req_target;
    logic [31:0] ret_target;

    // RAS side-effect strobes, only ever asserted on the accepting edge.
    logic        ras_push;
    logic        ras_pop;
    logic        accept_ok;

    // Decode the winning request in priority order.
    always_comb begin
        win_exc  = Exception;
        win_ret  = !Exception && Return;
        win_call = !Exception && !Return && Call;
        win_br   = !Exception && !Return && !Call && BranchTaken;
        any_req  = Exception || Return || Call || BranchTaken;
    end

`ifdef NEXTPC_RAS_EN
    localparam logic [RAS_AW:0] DEPTH_C = (RAS_AW + 1)'(RAS_DEPTH);

    // The pointer addresses the next free slot; the top entry sits one below.
    // When full, the next free slot is also the oldest entry, so a push simply
    // overwrites it and the circular order stays intact.
    logic [31:0]       ras_mem [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_ptr;
    logic [RAS_AW:0]   ras_count;
    logic [RAS_AW-1:0] ras_top_idx;
    logic [31:0]       ras_top;

    // Locate the current top-of-stack entry.
    always_comb begin
        ras_top_idx = ras_ptr - RAS_AW'(1);
        ras_top     = ras_mem[ras_top_idx];
        RasEmpty    = (ras_count == '0);
        RasFull     = (ras_count == DEPTH_C);
    end

    // Return takes the stack top when available, else the supplied target.
    always_comb begin
        ret_target = RasEmpty ? JumpTarget : ras_top;
    end

    // Stack storage is written on push only and needs no reset.
    always_ff @(posedge Clock) begin
        if (ras_push) begin
            ras_mem[ras_ptr] <= LinkAddr;
        end
    end

    // Pointer and occupancy count; count saturates at the stack depth.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr + RAS_AW'(1);
            if (ras_count != DEPTH_C) begin
                ras_count <= ras_count + (RAS_AW + 1)'(1);
            end
        end else if (ras_pop) begin
            ras_ptr   <= ras_ptr - RAS_AW'(1);
            ras_count <= ras_count - (RAS_AW + 1)'(1);
        end
    end
`else
    // No stack: Return falls back to JumpTarget and the flags are fixed.
    logic unused_cfg;

    always_comb begin
        ret_target = JumpTarget;
        RasEmpty   = 1'b1;
        RasFull    = 1'b0;
        unused_cfg = ^{LinkAddr, 32'(RAS_DEPTH), 32'(RAS_AW), ras_push, ras_pop};
    end
`endif

    // Select the target of the winning request and force word alignment.
    always_comb begin
        req_target = BranchTarget;
        if (win_exc) begin
            req_target = EXC_VECTOR;
        end else if (win_ret) begin
            req_target = ret_target;
        end else if (win_call) begin
            req_target = JumpTarget;
        end else if (win_br) begin
            req_target = BranchTarget;
        end
        req_target[1:0] = 2'b00;
    end

    // A Call/Return is accepted only from IDLE; in PEND anything but an
    // exception is wrong-path and leaves the stack untouched.
    always_comb begin
        accept_ok = Reset && (state == IDLE);
        ras_push  = accept_ok && win_call;
        ras_pop   = accept_ok && win_ret && !RasEmpty;
    end

    // Next-state logic for the parking FSM.
    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        case (state)
            IDLE: begin
                if (Stall && any_req) begin
                    state_nxt       = PEND;
                    pend_target_nxt = req_target;
                end
            end
            PEND: begin
                if (Stall) begin
                    if (Exception) begin
                        pend_target_nxt = {EXC_VECTOR[31:2], 2'b00};
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and parked-target registers; reset discards any parked redirect.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= IDLE;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    // Drive the PC register: hold on stall, redirect, or let it self-increment.
    always_comb begin
        PCWrite = 1'b0;
        PCNext  = PC + 32'd4;
        Pending = (state == PEND);
        if (!Reset) begin
            PCWrite = 1'b0;
            PCNext  = '0;
        end else if (Stall) begin
            PCWrite = 1'b1;
            PCNext  = PC;
        end else if (state == PEND) begin
            PCWrite = 1'b1;
            PCNext  = Exception ? {EXC_VECTOR[31:2], 2'b00} : pend_target;
        end else if (any_req) begin
            PCWrite = 1'b1;
            PCNext  = req_target;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - directed self-checking bench for next_pc_unit

module tb_next_pc_unit;

    logic        Clock;
    logic        Reset;
    logic [31:0] PC;
    logic        Stall;
    logic        Exception;
    logic        Return;
    logic        Call;
    logic [31:0] JumpTarget;
    logic [31:0] LinkAddr;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] PCNext;
    logic        PCWrite;
    logic        Pending;
    logic        RasEmpty;
    logic        RasFull;

    int tests_run;
    int tests_failed;

    next_pc_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .PC          (PC),
        .Stall       (Stall),
        .Exception   (Exception),
        .Return      (Return),
        .Call        (Call),
        .JumpTarget  (JumpTarget),
        .LinkAddr    (LinkAddr),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .PCNext      (PCNext),
        .PCWrite     (PCWrite),
        .Pending     (Pending),
        .RasEmpty    (RasEmpty),
        .RasFull     (RasFull)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Program counter register the unit feeds.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            PC <= '0;
        end else if (PCWrite) begin
            PC <= PCNext;
        end else begin
            PC <= PC + 32'd4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        Stall        = 1'b0;
        Exception    = 1'b0;
        Return       = 1'b0;
        Call         = 1'b0;
        BranchTaken  = 1'b0;
        JumpTarget   = '0;
        LinkAddr     = '0;
        BranchTarget = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        Reset = 1'b0;
        step();
        step();

        // Reset state
        check("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("rst_pcnext", PCNext, 32'd0);
        check("rst_pending", {31'd0, Pending}, 32'd0);
        check("rst_rasempty", {31'd0, RasEmpty}, 32'd1);
        check("rst_rasfull", {31'd0, RasFull}, 32'd0);
        check("rst_pc", PC, 32'd0);

        // Release: self-increment 0,4,8
        Reset = 1'b1;
        #1;
        check("inc_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("inc_pcnext0", PCNext, 32'd4);
        step();
        check("inc_pc4", PC, 32'd4);
        step();
        check("inc_pc8", PC, 32'd8);
        check("inc_pcnext8", PCNext, 32'd12);

        // Priority: exception beats branch
        Exception = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h200;
        #1;
        check("prio_pcnext", PCNext, 32'h80);
        check("prio_pcwrite", {31'd0, PCWrite}, 32'd1);
        step();
        check("prio_pc", PC, 32'h80);
        Exception = 1'b0; BranchTarget = 32'h203;
        #1;
        check("br_align", PCNext, 32'h200);
        step();
        check("br_pc", PC, 32'h200);
        idle_inputs();

        // Stall park
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h400;
        #1;
        check("park_hold", PCNext, 32'h200);
        check("park_hold_wr", {31'd0, PCWrite}, 32'd1);
        check("park_pend0", {31'd0, Pending}, 32'd0);
        step();
        check("park_pend1", {31'd0, Pending}, 32'd1);
        BranchTarget = 32'h500;
        #1;
        check("park_hold2", PCNext, 32'h200);
        step();
        BranchTaken = 1'b0; Stall = 1'b0;
        #1;
        check("park_issue", PCNext, 32'h400);
        check("park_issue_wr", {31'd0, PCWrite}, 32'd1);
        step();
        check("park_pc", PC, 32'h400);
        check("park_pend_clr", {31'd0, Pending}, 32'd0);
        check("park_after", PCNext, 32'h404);
        check("park_after_wr", {31'd0, PCWrite}, 32'd0);

        // Exception overrides a parked branch
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h600;
        step();
        BranchTaken = 1'b0; Exception = 1'b1;
        step();
        Exception = 1'b0; Stall = 1'b0;
        #1;
        check("exc_ovr", PCNext, 32'h80);
        step();
        check("exc_ovr_pc", PC, 32'h80);
        check("exc_ovr_pend", {31'd0, Pending}, 32'd0);

        // Wrong-path request while issuing a parked redirect is dropped
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h640;
        step();
        Stall = 1'b0; BranchTarget = 32'h680;
        #1;
        check("wrongpath", PCNext, 32'h640);
        step();
        idle_inputs();

        // Reset mid-stall discards the parked redirect
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h700;
        step();
        check("mid_pend", {31'd0, Pending}, 32'd1);
        Reset = 1'b0;
        #1;
        check("mid_rst_wr", {31'd0, PCWrite}, 32'd0);
        check("mid_rst_next", PCNext, 32'd0);
        step();
        idle_inputs();
        Reset = 1'b1;
        #1;
        check("mid_rst_pend", {31'd0, Pending}, 32'd0);
        check("mid_rst_inc", PCNext, 32'd4);
        check("mid_rst_incwr", {31'd0, PCWrite}, 32'd0);
        step();

`ifdef NEXTPC_RAS_EN
        // Call then Return
        Call = 1'b1; LinkAddr = 32'h104; JumpTarget = 32'h300;
        #1;
        check("call_tgt", PCNext, 32'h300);
        step();
        check("call_nonempty", {31'd0, RasEmpty}, 32'd0);
        Call = 1'b0; Return = 1'b1; JumpTarget = 32'h999;
        #1;
        check("ret_tgt", PCNext, 32'h104);
        step();
        check("ret_empty", {31'd0, RasEmpty}, 32'd1);
        #1;
        check("ret_empty_jt", PCNext, 32'h998);
        step();
        Return = 1'b0;

        // Nine calls overflow a depth-8 stack
        for (int k = 1; k <= 9; k++) begin
            Call = 1'b1; LinkAddr = 32'h1000 + 32'(4 * k); JumpTarget = 32'h300;
            step();
        end
        Call = 1'b0;
        check("ras_full", {31'd0, RasFull}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            Return = 1'b1; JumpTarget = 32'h888;
            #1;
            check($sformatf("ras_pop%0d", i), PCNext, 32'h1000 + 32'(4 * (10 - i)));
            step();
        end
        check("ras_drained", {31'd0, RasEmpty}, 32'd1);
        #1;
        check("ras_pop9_jt", PCNext, 32'h888);
        step();
        Return = 1'b0;

        // Parked Call pushes once at acceptance
        Stall = 1'b1; Call = 1'b1; LinkAddr = 32'h2000; JumpTarget = 32'h310;
        step();
        Call = 1'b0; Stall = 1'b0;
        #1;
        check("pcall_issue", PCNext, 32'h310);
        step();
        Return = 1'b1; JumpTarget = 32'h444;
        #1;
        check("pcall_ret", PCNext, 32'h2000);
        step();
        Return = 1'b0;
        check("pcall_empty", {31'd0, RasEmpty}, 32'd1);
`else
        // Without the stack Return always uses JumpTarget
        Call = 1'b1; LinkAddr = 32'h104; JumpTarget = 32'h300;
        #1;
        check("norascall_tgt", PCNext, 32'h300);
        step();
        check("norascall_empty", {31'd0, RasEmpty}, 32'd1);
        Call = 1'b0; Return = 1'b1; JumpTarget = 32'h240;
        #1;
        check("norasret_tgt", PCNext, 32'h240);
        check("norasret_empty", {31'd0, RasEmpty}, 32'd1);
        check("norasret_full", {31'd0, RasFull}, 32'd0);
        step();
        Return = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Next-PC generator driving the `PCNext`/`PCWrite` inputs of the program counter register; it is the producer end of the PC update interface. It arbitrates exception, return, call and branch redirects and holds the PC during fetch stalls. It parks a redirect that arrives during a stall and issues it when the stall ends. An optional return-address stack (RAS) supplies return targets.

## Interface
- `EXC_VECTOR`, 32'h00000080, exception redirect address
- `RAS_DEPTH`, 8, RAS entries (power of two, ≥2)
- `RAS_AW`, 3, log2(`RAS_DEPTH`)

- `Clock`  in  1  single clock; all state updates on posedge
- `Reset`  in  1  synchronous, active-low; sampled on posedge `Clock`
- `PC`  in  32  current PC from the program counter register
- `Stall`  in  1  fetch cannot advance; PC must hold
- `Exception`  in  1  redirect to `EXC_VECTOR`
- `Return`  in  1  return redirect
- `Call`  in  1  call redirect to `JumpTarget`; pushes `LinkAddr`
- `JumpTarget`  in  32  call target; return target when RAS is absent or empty
- `LinkAddr`  in  32  return address pushed on `Call`
- `BranchTaken`  in  1  taken branch redirect
- `BranchTarget`  in  32  branch target
- `PCNext`  out  32  next PC value
- `PCWrite`  out  1  1 = load `PCNext`; 0 = PC register self-increments by 4
- `Pending`  out  1  a parked redirect is waiting
- `RasEmpty`  out  1  RAS holds no entries (constant 1 when RAS is compiled out)
- `RasFull`  out  1  RAS holds `RAS_DEPTH` entries (constant 0 when RAS is compiled out)

## Operation
- **Priority:** Exception > Return > Call > BranchTaken. Only the winner is accepted; losers are dropped in that cycle.
- **Target:**
  - Exception → `EXC_VECTOR`
  - Return → RAS top, or `JumpTarget` if RAS is empty or compiled out
  - Call → `JumpTarget`
  - Branch → `BranchTarget`
  - All targets have bits [1:0] forced to 0.
- **States:** IDLE and PEND. PEND holds the register `PendTarget`. `Pending` = (state == PEND).
- **Outputs are combinational from the inputs and the registered state:**
  - `Reset`=0: `PCWrite`=0, `PCNext`=0.
  - `Stall`=1: `PCWrite`=1, `PCNext`=`PC` (hold).
  - `Stall`=0, with a new request or in PEND: `PCWrite`=1, `PCNext` = selected target (see next item).
  - `Stall`=0, no request, IDLE: `PCWrite`=0, `PCNext`=`PC`+4.
- **Selection with `Stall`=0:**
  - In PEND, `PendTarget` is issued, and any new non-exception request is dropped as wrong-path.
  - A new Exception always overrides `PendTarget`.
- **Transitions:**
  - IDLE→PEND: accepted request while `Stall`=1; its target is latched into `PendTarget`.
  - PEND→PEND: Exception while `Stall`=1 replaces `PendTarget`. Any other request is dropped.
  - PEND→IDLE: `Stall`=0 (the pending or exception target is issued this cycle).
- **RAS side effects** happen exactly once, on the edge where the request is accepted, whether it is issued or parked. They never happen at a deferred issue.
  - Accepted Call pushes `LinkAddr`.
  - Accepted Return pops when the stack is non-empty.
- **RAS arithmetic:**
  - Circular buffer with a `RAS_AW`-bit top pointer wrapping modulo `RAS_DEPTH`, plus a count saturating at 0..`RAS_DEPTH`.
  - Push when full overwrites the oldest entry; the count stays at `RAS_DEPTH`.
  - Pop when empty is a no-op.

## Timing
- Redirect latency is zero cycles to `PCNext`. `PC` takes the new value on the next posedge.
- A parked redirect is issued in the first cycle with `Stall`=0.
- Reset, on the posedge where `Reset`=0:
  - state becomes IDLE and `PendTarget`=0
  - RAS count and pointer become 0, so `RasEmpty`=1 and `RasFull`=0
  - reset mid-stall discards any pending redirect.
- Returning from reset: `Reset` is released at the same posedge the PC register leaves reset. The PC register is then 0 and increments by 4 while no requests arrive.

## Configuration
- `NEXTPC_RAS_EN` defined: the RAS is instantiated, and Return targets come from the RAS top when it is non-empty.
- `NEXTPC_RAS_EN` undefined:
  - there is no RAS storage
  - Return uses `JumpTarget`, and Call only redirects
  - `RasEmpty`=1 and `RasFull`=0 constantly.

## Test plan
- **Reset:** hold `Reset`=0 for 2 cycles → `PCWrite`=0, `PCNext`=0, `Pending`=0, `RasEmpty`=1. Release with no requests → `PCWrite`=0, `PC` sequence 0,4,8.
- **Priority:** `Exception`=`BranchTaken`=1 with `BranchTarget`=0x200 → `PCNext`=0x80, `PCWrite`=1. Next: `BranchTarget`=0x203 alone → `PCNext`=0x200.
- **Stall park:** `Stall`=1, `BranchTaken`=1, target 0x400 → `PCNext`=`PC`, `Pending`=1. Next: `BranchTaken`=1, target 0x500 → still parked at 0x400. `Stall`=0 → `PCNext`=0x400, `Pending`=0 the next cycle.
- **Exception override:** parked 0x400 plus `Exception`=1 during the stall → on stall release `PCNext`=0x80.
- **RAS (EN):**
  - Call with `LinkAddr`=0x104, `JumpTarget`=0x300, then Return with `JumpTarget`=0x999 → `PCNext`=0x104 and `RasEmpty`=1 after.
  - A 9th Call with depth 8 → `RasFull`=1. Then 8 Returns yield links 9..2 in order, and a 9th Return uses `JumpTarget`.
- **RAS (no EN):** Call with link 0x104, then Return with `JumpTarget`=0x240 → `PCNext`=0x240, `RasEmpty`=1 throughout.
